// File: rtl/sensor_cond_if.sv
// Sample bus into the conditioner and the classified result bus out of it.
interface sensor_cond_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] nivel;
  logic              nivel_valid;
  logic              aviso;
  logic              alarma;
  logic [1:0]        estado_sens;
  logic [DATA_W-1:0] nivel_pico;

  modport master (
    output nivel, nivel_valid,
    input  aviso, alarma, estado_sens, nivel_pico
  );

  modport slave (
    input  nivel, nivel_valid,
    output aviso, alarma, estado_sens, nivel_pico
  );
endinterface

// File: rtl/sensor_cond.sv
// Input conditioning ahead of the alarm/ventilation controller:
// switch/contact debounce, thresholded level classifier with hysteresis
// and persistence, and a peak-hold of the level for display.
//
// state  | meaning
// NORMAL | level below warning band
// AVISO  | level in warning band
// ALARMA | level in alarm band
module sensor_cond #(
  parameter int DATA_W    = 8,
  parameter int TH_AVISO  = 100,
  parameter int TH_ALARMA = 180,
  parameter int HYST      = 10,
  parameter int PERSIST   = 3,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_raw,
  input  logic         vent_raw,
  output logic         EN,
  output logic         vent,
  sensor_cond_if.slave bus
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    AVISO  = 2'b01,
    ALARMA = 2'b10
  } cls_e;

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = $clog2(PERSIST + 1);
  localparam logic [DBW:0]    DB_LIM  = (DBW + 1)'(DB_CYCLES);
  localparam logic [PW:0]     P_LIM   = (PW + 1)'(PERSIST);
  localparam logic [DATA_W:0] TH_AL   = (DATA_W + 1)'(TH_ALARMA);
  localparam logic [DATA_W:0] TH_AL_H = (DATA_W + 1)'(TH_ALARMA - HYST);
  localparam logic [DATA_W:0] TH_AV   = (DATA_W + 1)'(TH_AVISO);
  localparam logic [DATA_W:0] TH_AV_H = (DATA_W + 1)'(TH_AVISO - HYST);

  // bit 0 = enable switch, bit 1 = ventilation contact
  logic [1:0]     sync1_q, sync1_d;
  logic [1:0]     sync2_q, sync2_d;
  logic [1:0]     db_q, db_d;
  logic [DBW-1:0] dbcnt_q [2];
  logic [DBW-1:0] dbcnt_d [2];
  logic [DBW:0]   db_inc  [2];

  cls_e           state_q, state_d;
  cls_e           pend_q, pend_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [PW:0]    pinc;
  cls_e           cls;
  logic [DATA_W:0] nivel_x;

  logic [DATA_W-1:0] pico_q, pico_d;
  logic              en_rise;

  // Synchronize both raw inputs and restart the stability count on any bounce.
  always_comb begin
    sync1_d = {vent_raw, en_raw};
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < 2; i++) begin
      dbcnt_d[i] = '0;
      db_inc[i]  = {1'b0, dbcnt_q[i]} + (DBW + 1)'(1);
      if (sync2_q[i] != db_q[i]) begin
        if (db_inc[i] == DB_LIM) begin
          db_d[i] = sync2_q[i];
        end else begin
          dbcnt_d[i] = db_inc[i][DBW-1:0];
        end
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      dbcnt_q[0] <= '0;
      dbcnt_q[1] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      dbcnt_q[0] <= dbcnt_d[0];
      dbcnt_q[1] <= dbcnt_d[1];
    end
  end

  // Classify the sample, then require PERSIST consecutive agreeing samples to move.
  always_comb begin
    nivel_x = {1'b0, bus.nivel};
    cls     = NORMAL;
    if (nivel_x >= TH_AL || (state_q == ALARMA && nivel_x >= TH_AL_H)) begin
      cls = ALARMA;
    end else if (nivel_x >= TH_AV || (state_q != NORMAL && nivel_x >= TH_AV_H)) begin
      cls = AVISO;
    end
    state_d = state_q;
    pend_d  = pend_q;
    pcnt_d  = pcnt_q;
    pinc    = '0;
    if (bus.nivel_valid) begin
      if (cls == state_q) begin
        pcnt_d = '0;
      end else begin
        if (cls == pend_q) begin
          pinc = {1'b0, pcnt_q} + (PW + 1)'(1);
        end else begin
          pend_d = cls;
          pinc   = (PW + 1)'(1);
        end
        if (pinc == P_LIM) begin
          state_d = cls;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pinc[PW-1:0];
        end
      end
    end
  end

  // Classifier state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      pend_q  <= NORMAL;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Peak hold; a fresh enable clears it and wins over a coincident sample.
  always_comb begin
    en_rise = db_d[0] & ~db_q[0];
    pico_d  = pico_q;
    if (en_rise) begin
      pico_d = '0;
    end else if (bus.nivel_valid && bus.nivel > pico_q) begin
      pico_d = bus.nivel;
    end
  end

  // Peak register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pico_q <= '0;
    end else begin
      pico_q <= pico_d;
    end
  end

  assign EN              = db_q[0];
  assign vent            = db_q[1];
  assign bus.aviso       = (state_q == AVISO);
  assign bus.alarma      = (state_q == ALARMA);
  assign bus.estado_sens = state_q;
  assign bus.nivel_pico  = pico_q;

endmodule

// File: tb/tb_sensor_cond.sv
// Directed bench for sensor_cond: classifier vector table plus hand-built
// sequences for async reset, debounce timing, gapped samples and peak clear.
module tb_sensor_cond;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en_raw = 1'b0;
  logic vent_raw = 1'b0;
  logic EN, vent;
  int   errors = 0;
  int   checks = 0;
  int   pico_m = 0;
  int   rise_at;

  sensor_cond_if #(.DATA_W(8)) bus ();

  sensor_cond dut (
    .clk      (clk),
    .reset    (reset),
    .en_raw   (en_raw),
    .vent_raw (vent_raw),
    .EN       (EN),
    .vent     (vent),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] nivel;
    logic [1:0] est;
  } vec_t;

  localparam int N = 50;
  vec_t tbl [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input logic [7:0] v);
    bus.nivel       = v;
    bus.nivel_valid = 1'b1;
    if (int'(v) > pico_m) pico_m = int'(v);
    tick();
    bus.nivel_valid = 1'b0;
  endtask

  task automatic chk_cls(input string name, input logic [1:0] est);
    chk({name, " estado"}, int'(bus.estado_sens), int'(est));
    chk({name, " aviso"},  int'(bus.aviso),  int'(est == 2'b01));
    chk({name, " alarma"}, int'(bus.alarma), int'(est == 2'b10));
  endtask

  initial begin
    tbl = '{
      '{8'd120, 2'b00}, '{8'd120, 2'b00}, '{8'd120, 2'b01},
      '{8'd89,  2'b01}, '{8'd89,  2'b01}, '{8'd89,  2'b00},
      '{8'd120, 2'b00}, '{8'd90,  2'b00}, '{8'd120, 2'b00},
      '{8'd50,  2'b00},
      '{8'd99,  2'b00}, '{8'd99,  2'b00}, '{8'd99,  2'b00},
      '{8'd100, 2'b00}, '{8'd100, 2'b00}, '{8'd100, 2'b01},
      '{8'd90,  2'b01}, '{8'd90,  2'b01}, '{8'd90,  2'b01},
      '{8'd89,  2'b01}, '{8'd89,  2'b01}, '{8'd89,  2'b00},
      '{8'd200, 2'b00}, '{8'd200, 2'b00}, '{8'd200, 2'b10},
      '{8'd175, 2'b10}, '{8'd175, 2'b10}, '{8'd175, 2'b10},
      '{8'd175, 2'b10}, '{8'd175, 2'b10},
      '{8'd169, 2'b10}, '{8'd169, 2'b10}, '{8'd169, 2'b01},
      '{8'd95,  2'b01}, '{8'd95,  2'b01}, '{8'd95,  2'b01},
      '{8'd89,  2'b01}, '{8'd89,  2'b01}, '{8'd89,  2'b00},
      '{8'd179, 2'b00}, '{8'd179, 2'b00}, '{8'd179, 2'b01},
      '{8'd180, 2'b01}, '{8'd180, 2'b01}, '{8'd180, 2'b10},
      '{8'd170, 2'b10}, '{8'd170, 2'b10},
      '{8'd10,  2'b10}, '{8'd10,  2'b10}, '{8'd10,  2'b00}
    };
    bus.nivel       = '0;
    bus.nivel_valid = 1'b0;

    // reset state
    tick();
    tick();
    chk_cls("rst", 2'b00);
    chk("rst EN", int'(EN), 0);
    chk("rst vent", int'(vent), 0);
    chk("rst pico", int'(bus.nivel_pico), 0);
    reset = 1'b1;
    tick();

    // classifier vector table
    for (int i = 0; i < N; i++) begin
      sample(tbl[i].nivel);
      chk_cls($sformatf("vec%0d", i), tbl[i].est);
      chk($sformatf("vec%0d pico", i), int'(bus.nivel_pico), pico_m);
    end

    // direct jump NORMAL->ALARMA with idle gaps
    sample(8'd200);
    chk_cls("gap s1", 2'b00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cls($sformatf("gap idle%0d", i), 2'b00);
    end
    sample(8'd200);
    chk_cls("gap s2", 2'b00);
    sample(8'd200);
    chk_cls("gap s3", 2'b10);
    chk("gap pico", int'(bus.nivel_pico), 200);

    // async reset mid-persistence
    sample(8'd120);
    chk_cls("pre-rst", 2'b10);
    #3 reset = 1'b0;
    #1;
    chk_cls("async rst", 2'b00);
    chk("async rst EN", int'(EN), 0);
    chk("async rst vent", int'(vent), 0);
    chk("async rst pico", int'(bus.nivel_pico), 0);
    #2 reset = 1'b1;
    pico_m = 0;
    sample(8'd120);
    chk_cls("post-rst s1", 2'b00);
    sample(8'd120);
    chk_cls("post-rst s2", 2'b00);
    sample(8'd120);
    chk_cls("post-rst s3", 2'b01);
    sample(8'd200);
    chk("pico before clear", int'(bus.nivel_pico), 200);

    // enable bounce, then clean edge coinciding with a sample
    for (int t = 0; t < 8; t++) begin
      en_raw = ~en_raw;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk($sformatf("bounce t%0d k%0d EN", t, k), int'(EN), 0);
      end
    end
    en_raw = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("en settle %0d", k), int'(EN), 0);
    end
    bus.nivel       = 8'd150;
    bus.nivel_valid = 1'b1;
    tick();
    bus.nivel_valid = 1'b0;
    chk("en edge 18", int'(EN), 1);
    chk("pico cleared", int'(bus.nivel_pico), 0);
    sample(8'd60);
    chk("pico after clear", int'(bus.nivel_pico), 60);

    // vent glitch shorter than the debounce window
    vent_raw = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    vent_raw = 1'b0;
    rise_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (vent && rise_at == 0) rise_at = k;
      tick();
    end
    chk("vent glitch ignored", rise_at, 0);

    // clean vent edge
    vent_raw = 1'b1;
    rise_at = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (vent && rise_at == 0) rise_at = k;
    end
    chk("vent edge latency", rise_at, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
